// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package riscv_fetch_pkg;
  localparam int          FETCH_BITS  = 64;
  localparam int          FETCH_N     = 32;
  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_BITS-1:0] pc;
    logic [FETCH_N-1:0]    instr;
  } fetch_entry_t;

  // Saturating 64-bit accumulate for the performance counters.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] d);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, d};
    return s[64] ? '1 : s[63:0];
  endfunction
endpackage

// File: rtl/riscv_fetch_unit_fetch_queue.sv
// Synchronous FIFO with flush; count is DEPTH+1 states wide so full and empty are distinct.
module fetch_queue #(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk)
    if (push && !flush) mem[wptr] <= wdata;

  assign rdata = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/riscv_fetch_unit.sv
// Fetch front end: fetch PC, credit-limited imem requests, prefetch queue, redirect squash.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/squashed/stall counters.
module riscv_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int              Bits    = FETCH_BITS,
  parameter int              N       = FETCH_N,
  parameter int              Depth   = 4,
  parameter logic [Bits-1:0] ResetPC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [Bits-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [N-1:0]    imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [Bits-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [Bits-1:0] dec_pc,
  output logic [N-1:0]    dec_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]     perf_fetched,
  output logic [63:0]     perf_squashed,
  output logic [63:0]     perf_stall
`endif
);
  localparam int CW = $clog2(Depth) + 1;

  logic [Bits-1:0] fetch_pc;
  logic            run;
  logic [CW-1:0]   discard;

  logic [CW-1:0]   q_count, pcq_count;
  logic            q_full, q_empty, pcq_full, pcq_empty;
  fetch_entry_t    q_wdata, head;
  logic [Bits-1:0] pcq_rdata;

  logic credit, req_fire, rsp_drop, q_push, pcq_pop, dec_fire;

  // Every outstanding request owns a queue slot, so responses always fit.
  assign credit   = ({1'b0, q_count} + {1'b0, pcq_count}) < (CW+1)'(Depth);
  assign imem_req_valid = run && credit && !redirect_valid && !q_full && !pcq_full;
  assign imem_req_addr  = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;

  assign pcq_pop  = imem_rsp_valid && !pcq_empty;
  assign rsp_drop = imem_rsp_valid && (redirect_valid || discard != '0);
  assign q_push   = imem_rsp_valid && !rsp_drop;
  assign q_wdata  = '{pc: pcq_rdata, instr: imem_rsp_data};

  assign dec_valid = !q_empty;
  assign dec_fire  = dec_valid && dec_ready;
  assign dec_pc    = dec_valid ? head.pc    : '0;
  assign dec_instr = dec_valid ? head.instr : '0;

  fetch_queue #(.W($bits(fetch_entry_t)), .DEPTH(Depth)) u_pfq (
    .clk(clk), .rst(rst), .push(q_push), .pop(dec_fire), .flush(redirect_valid),
    .wdata(q_wdata), .rdata(head), .count(q_count), .full(q_full), .empty(q_empty)
  );

  // In-flight PCs survive a redirect: the squashed responses still return and must pop them.
  fetch_queue #(.W(Bits), .DEPTH(Depth)) u_pcq (
    .clk(clk), .rst(rst), .push(req_fire), .pop(pcq_pop), .flush(1'b0),
    .wdata(fetch_pc), .rdata(pcq_rdata), .count(pcq_count), .full(pcq_full), .empty(pcq_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= ResetPC;
      run      <= 1'b0;
      discard  <= '0;
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~Bits'(3);
        discard  <= pcq_count - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + Bits'(INSTR_BYTES);
        if (imem_rsp_valid && discard != '0) discard <= discard - 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] squash_inc;
  assign squash_inc = 64'(rsp_drop) + (redirect_valid ? 64'(q_count) - 64'(dec_fire) : 64'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
      perf_stall    <= '0;
    end else begin
      perf_fetched  <= sat_add(perf_fetched, 64'(q_push));
      perf_squashed <= sat_add(perf_squashed, squash_inc);
      perf_stall    <= sat_add(perf_stall, 64'(dec_ready && !dec_valid));
    end
  end
`endif
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboarded bench: in-order memory model with programmable latency, expected decode PC stream queue.
module tb_riscv_fetch_unit;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [63:0] WRAP_PC  = 64'hFFFF_FFFF_FFFF_FFF8;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [63:0] imem_req_addr;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [63:0] dec_pc;
  logic [31:0] dec_instr;

  logic        req2_valid, req2_ready, rsp2_valid, dec2_valid;
  logic [63:0] req2_addr, dec2_pc;
  logic [31:0] rsp2_data, dec2_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] perf_fetched, perf_squashed, perf_stall;
  logic [63:0] perf2_fetched, perf2_squashed, perf2_stall;
  bit          perf_done;
`endif

  riscv_fetch_unit #(.ResetPC(RESET_PC)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed), .perf_stall(perf_stall)
`endif
  );

  riscv_fetch_unit #(.ResetPC(WRAP_PC)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(req2_valid), .imem_req_ready(req2_ready), .imem_req_addr(req2_addr),
    .imem_rsp_valid(rsp2_valid), .imem_rsp_data(rsp2_data),
    .redirect_valid(1'b0), .redirect_pc(64'h0),
    .dec_valid(dec2_valid), .dec_ready(1'b1), .dec_pc(dec2_pc), .dec_instr(dec2_instr)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf2_fetched), .perf_squashed(perf2_squashed), .perf_stall(perf2_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0, nfail = 0;
  int cyc = 0, lat = 1, nreq = 0, pops = 0, k2 = 0, f2 = 0;

  typedef struct { logic [63:0] addr; int due; } pend_t;
  pend_t       pend[$];
  logic [63:0] sb[$];

  logic        prev_rstall, prev_dstall, p2_v;
  logic [63:0] prev_addr, prev_dpc, p2_a;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic sb_fill(input logic [63:0] start);
    sb.delete();
    for (int i = 0; i < 256; i++) sb.push_back(start + 64'(4 * i));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT: decode scoreboard, stability checks and in-order memory.
  always @(negedge clk) begin
    if (!rst) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      sb_fill(RESET_PC);
      nreq = 0; pops = 0;
      prev_rstall = 1'b0; prev_dstall = 1'b0;
    end else begin
      if (prev_rstall && imem_req_valid) chk("req_addr_stable", imem_req_addr, prev_addr);
      if (prev_dstall) begin
        chk("dec_valid_held", 64'(dec_valid), 64'd1);
        chk("dec_pc_stable", dec_pc, prev_dpc);
      end
      if (dec_valid && dec_ready) begin
        pops++;
        if (sb.size() == 0) chk("dec_unexpected", dec_pc, 64'hDEAD_BEEF);
        else begin
          logic [63:0] e;
          e = sb.pop_front();
          chk("dec_pc", dec_pc, e);
          chk("dec_instr", 64'(dec_instr), 64'(mem_word(e)));
        end
      end
      if (redirect_valid) sb_fill({redirect_pc[63:2], 2'b00});
      prev_rstall = imem_req_valid && !imem_req_ready;
      prev_addr   = imem_req_addr;
      prev_dstall = dec_valid && !dec_ready && !redirect_valid;
      prev_dpc    = dec_pc;

      imem_rsp_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        pend.delete(0);
      end
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{imem_req_addr, cyc + 1 + lat});
        nreq++;
      end
    end
  end

  // Wrap DUT: 1-cycle memory, exactly three requests granted per reset.
  always @(negedge clk) begin
    if (!rst) begin
      k2 = 0; f2 = 0; p2_v = 1'b0; p2_a = '0;
      rsp2_valid = 1'b0; rsp2_data = '0; req2_ready = 1'b1;
`ifdef FETCH_PERF_CNT_EN
      perf_done = 1'b0;
`endif
    end else begin
      if (dec2_valid) begin
        chk("wrap_pc", dec2_pc, WRAP_PC + 64'(4 * k2));
        chk("wrap_instr", 64'(dec2_instr), 64'(mem_word(WRAP_PC + 64'(4 * k2))));
        k2++;
      end
      rsp2_valid = p2_v;
      rsp2_data  = mem_word(p2_a);
      p2_v = req2_valid && req2_ready;
      p2_a = req2_addr;
      if (p2_v) f2++;
      req2_ready = (f2 < 3);
`ifdef FETCH_PERF_CNT_EN
      if (k2 == 3 && !perf_done) begin
        chk("perf_fetched", perf2_fetched, 64'd3);
        perf_done = 1'b1;
      end
`endif
    end
  end

  task automatic do_reset(input int l, input logic rr, input logic dr);
    @(posedge clk); #1;
    rst = 1'b0; lat = l; imem_req_ready = rr; dec_ready = dr; redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_dec_pc", dec_pc, 64'd0);
    chk("rst_dec_instr", 64'(dec_instr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("post_rst_dec_valid", 64'(dec_valid), 64'd0);
  endtask

  initial begin
    int  p0;
    bit  found;
    rst = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;

    // Streaming with 1-cycle memory
    do_reset(1, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t1_throughput", 64'(pops >= 12), 64'd1);

    // Decode back-pressure: credit caps requests at Depth
    do_reset(1, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t2_nreq", 64'(nreq), 64'd4);
    chk("t2_req_valid", 64'(imem_req_valid), 64'd0);
    chk("t2_dec_valid", 64'(dec_valid), 64'd1);
    chk("t2_dec_pc", dec_pc, 64'd0);
    chk("t2_dec_instr", 64'(dec_instr), 64'(mem_word(64'd0)));
    @(posedge clk); #1 dec_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("t2_drain", 64'(pops >= 6), 64'd1);

    // Redirect with two requests in flight, 3-cycle memory
    do_reset(3, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (pend.size() == 2) found = 1'b1;
    end
    chk("t3_two_inflight", 64'(found), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 64'h100; p0 = pops;
    @(posedge clk); #1 redirect_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t3_progress", 64'((pops - p0) >= 5), 64'd1);
    // Back-to-back redirects: only the last target survives
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 64'h300;
    @(posedge clk); #1 redirect_pc = 64'h400; p0 = pops;
    @(posedge clk); #1 redirect_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t3b_progress", 64'((pops - p0) >= 5), 64'd1);

    // Memory back-pressure: address held
    do_reset(1, 1'b0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("t4_req_valid", 64'(imem_req_valid), 64'd1);
      chk("t4_req_addr", imem_req_addr, 64'd0);
    end
    @(posedge clk); #1 imem_req_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t4_progress", 64'(pops >= 4), 64'd1);

    // Redirect on a full queue while decode pops; low target bits ignored
    do_reset(1, 1'b1, 1'b0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("t5_full_req_valid", 64'(imem_req_valid), 64'd0);
    @(posedge clk); #1;
    dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h206; p0 = pops;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5_flushed", 64'(dec_valid), 64'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t5_progress", 64'((pops - p0) >= 6), 64'd1);
    chk("wrap_count", 64'(k2), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", nchk);
    $fatal(1, "watchdog");
  end
endmodule
